// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter fed by a valid/ready byte FIFO.
// Bytes are popped into a shift register, so queued writes never touch a frame in flight.
module uart_tx_buffered #(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       dout,
    output logic       busy,
    output logic       overflow
);

    localparam int BAUD_DIV = CLOCK_FREQ / BAUD;
    localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [ADDR_W:0]   FULL_CNT  = (ADDR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;

    state_t           state_q, state_d;
    logic             dout_q, dout_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic             overflow_q, overflow_d;

    logic push;
    logic pop;
    logic baud_end;

    assign ready    = (count_q != FULL_CNT);
    assign push     = valid && ready;
    assign baud_end = (baud_cnt_q == BAUD_LAST);

    assign dout     = dout_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != S_IDLE) || (count_q != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data;
        end
    end

    always_comb begin
        state_d    = state_q;
        dout_d     = dout_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        baud_cnt_d = baud_cnt_q;
        pop        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                dout_d = 1'b1;
                if (count_q != '0) begin
                    pop        = 1'b1;
                    shift_d    = mem_q[rd_ptr_q];
                    dout_d     = 1'b0;
                    baud_cnt_d = '0;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (baud_end) begin
                    dout_d     = shift_q[0];
                    bit_idx_d  = '0;
                    baud_cnt_d = '0;
                    state_d    = S_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        dout_d  = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        shift_d   = shift_q >> 1;
                        dout_d    = shift_q[1];
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    baud_cnt_d = '0;
                    state_d    = S_IDLE;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Full FIFO rejects a push even when a pop lands on the same edge.
    always_comb begin
        wr_ptr_d   = wr_ptr_q + ADDR_W'(push);
        rd_ptr_d   = rd_ptr_q + ADDR_W'(pop);
        count_d    = count_q + (ADDR_W + 1)'(push) - (ADDR_W + 1)'(pop);
        overflow_d = valid && !ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= S_IDLE;
            dout_q     <= 1'b1;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            baud_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            dout_q     <= dout_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            baud_cnt_q <= baud_cnt_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered at BAUD_DIV=10.
// A line decoder samples dout mid-bit and queues received bytes with start cycles.
module tb_uart_tx_buffered;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic [7:0] data;
    logic       ready;
    logic       dout;
    logic       busy;
    logic       overflow;

    uart_tx_buffered #(
        .CLOCK_FREQ(1000),
        .BAUD      (100),
        .FIFO_DEPTH(16),
        .ADDR_W    (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .valid   (valid),
        .data    (data),
        .ready   (ready),
        .dout    (dout),
        .busy    (busy),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [7:0] rx_q[$];
    int         rx_t[$];

    typedef struct {
        logic [7:0] data;
        logic [9:0] line;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_rx(input int n, input int budget);
        int b = 0;
        while (rx_q.size() < n && b < budget) begin
            tick();
            b++;
        end
        if (rx_q.size() < n) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_rx: got %0d bytes expected %0d", rx_q.size(), n);
        end
    endtask

    task automatic wait_idle(input int budget);
        int b = 0;
        while (busy && b < budget) begin
            tick();
            b++;
        end
        chk("wait_idle", {31'd0, busy}, 32'd0);
    endtask

    // Line decoder: start at first low sample, bits sampled at offset 5+10*j.
    bit         in_frame = 1'b0;
    int         st       = 0;
    int         off      = 0;
    logic [7:0] sh       = '0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            in_frame = 1'b0;
        end else if (!in_frame) begin
            if (dout == 1'b0) begin
                in_frame = 1'b1;
                st       = cyc;
            end
        end else begin
            off = cyc - st;
            if (off >= 15 && off <= 85 && (off - 5) % 10 == 0)
                sh[(off - 15) / 10] = dout;
            if (off == 95) begin
                chk("stop_bit", {31'd0, dout}, 32'd1);
                rx_q.push_back(sh);
                rx_t.push_back(st);
                in_frame = 1'b0;
            end
        end
    end

    initial begin
        string s;
        int    wbad;
        int    bc;
        int    bad;
        int    b;
        logic  exp_d;
        logic [31:0] got;

        vecs[0] = '{8'h68, 10'b1011010000};
        vecs[1] = '{8'h00, 10'b1000000000};
        vecs[2] = '{8'hFF, 10'b1111111110};
        vecs[3] = '{8'hA5, 10'b1101001010};
        vecs[4] = '{8'h01, 10'b1000000010};
        vecs[5] = '{8'h80, 10'b1100000000};

        rst   = 1'b1;
        valid = 1'b0;
        data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_dout", {31'd0, dout}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        rst = 1'b0;
        tick();

        // Single frames: exact waveform and busy duration.
        for (int v = 0; v < 6; v++) begin
            rx_q.delete();
            rx_t.delete();
            valid = 1'b1;
            data  = vecs[v].data;
            tick();
            valid = 1'b0;
            wbad  = 0;
            bc    = 0;
            for (int k = 0; k <= 110; k++) begin
                if (k >= 1 && k <= 100)
                    exp_d = vecs[v].line[(k - 1) / 10];
                else
                    exp_d = 1'b1;
                if (dout !== exp_d) wbad++;
                if (busy) bc++;
                tick();
            end
            chk($sformatf("wave_%02h", vecs[v].data), wbad, 0);
            chk($sformatf("busy_cyc_%02h", vecs[v].data), bc, 101);
            got = (rx_q.size() == 1) ? {24'd0, rx_q[0]} : 32'hDEAD;
            chk($sformatf("rx_%02h", vecs[v].data), got, {24'd0, vecs[v].data});
        end

        // Back-to-back burst of 15 bytes.
        rx_q.delete();
        rx_t.delete();
        s   = "hitsz2024311668";
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            if (!ready) bad++;
            valid = 1'b1;
            data  = s[i];
            tick();
        end
        valid = 1'b0;
        chk("burst_ready", bad, 0);
        wait_rx(15, 2000);
        if (rx_q.size() >= 15) begin
            for (int i = 0; i < 15; i++)
                chk($sformatf("burst_byte%0d", i), {24'd0, rx_q[i]}, {24'd0, s[i]});
            for (int i = 1; i < 15; i++)
                chk($sformatf("burst_pitch%0d", i), rx_t[i] - rx_t[i-1], 101);
        end
        wait_idle(300);

        // Fill: 17 accepted, 18th overflows, 19th rejected on a pop edge.
        rx_q.delete();
        rx_t.delete();
        bad = 0;
        b   = 0;
        for (int i = 0; i < 17; i++) begin
            if (!ready) bad++;
            valid = 1'b1;
            data  = 8'h40 + 8'(i);
            tick();
            if (overflow) b++;
        end
        chk("fill_ready", bad, 0);
        chk("fill_no_ovf", b, 0);
        chk("full_ready", {31'd0, ready}, 32'd0);
        data = 8'hF0;
        tick();
        valid = 1'b0;
        chk("ovf_pulse", {31'd0, overflow}, 32'd1);
        tick();
        chk("ovf_clear", {31'd0, overflow}, 32'd0);
        repeat (83) tick();
        chk("full_before_pop", {31'd0, ready}, 32'd0);
        chk("stop_high", {31'd0, dout}, 32'd1);
        valid = 1'b1;
        data  = 8'hEE;
        tick();
        valid = 1'b0;
        chk("ovf_on_pop", {31'd0, overflow}, 32'd1);
        chk("ready_after_pop", {31'd0, ready}, 32'd1);
        chk("start_after_pop", {31'd0, dout}, 32'd0);
        wait_rx(17, 17 * 101 + 200);
        wait_idle(300);
        chk("fill_rx_count", rx_q.size(), 17);
        bad = 0;
        for (int i = 0; i < rx_q.size() && i < 17; i++)
            if (rx_q[i] !== 8'h40 + 8'(i)) bad++;
        chk("fill_order", bad, 0);

        // Reset mid-DATA with bytes queued.
        valid = 1'b1;
        data  = 8'hA5;
        tick();
        data = 8'h11;
        tick();
        data = 8'h22;
        tick();
        data = 8'h33;
        tick();
        valid = 1'b0;
        repeat (40) tick();
        rst = 1'b1;
        #1;
        chk("midrst_dout", {31'd0, dout}, 32'd1);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_ready", {31'd0, ready}, 32'd1);
        tick();
        rst = 1'b0;
        tick();
        rx_q.delete();
        rx_t.delete();
        valid = 1'b1;
        data  = 8'h31;
        tick();
        valid = 1'b0;
        wait_rx(1, 200);
        repeat (150) tick();
        chk("post_rst_count", rx_q.size(), 1);
        got = (rx_q.size() >= 1) ? {24'd0, rx_q[0]} : 32'hDEAD;
        chk("post_rst_byte", got, 32'h31);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        // Pointer wrap with random gaps.
        rx_q.delete();
        rx_t.delete();
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            b = 0;
            while (!ready && b < 500) begin
                tick();
                b++;
            end
            if (!ready) begin
                n_cmp++;
                n_fail++;
                $display("FAIL wrap_ready: got 0 expected 1 at byte %0d", i);
            end
            valid = 1'b1;
            data  = 8'(i);
            tick();
            valid = 1'b0;
        end
        wait_rx(40, 40 * 101 + 500);
        wait_idle(300);
        chk("wrap_count", rx_q.size(), 40);
        bad = 0;
        for (int i = 0; i < rx_q.size() && i < 40; i++)
            if (rx_q[i] !== 8'(i)) bad++;
        chk("wrap_order", bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
